// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle adder sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: controller state encoding (S_IDLE, S_RUN).
package adder_pkg;

  // Controller state encoding: waiting for a request, or walking the chunks.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage : adder_pkg

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder; the narrow datapath shared over several cycles.
// Latency: purely combinational, zero cycles.
// Backpressure: none; inputs map straight to outputs.
// Ports: a, b (N-bit operands), cin (carry in) -> sum (N-bit), cout (carry out).
module ripple_carry_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic c;

  always_comb begin
    c   = cin;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule : ripple_carry_adder

// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract built from one N-bit ripple adder reused LSB chunk first.
// Latency: WORDS cycles from the accepting start edge to the done pulse.
// Backpressure: start is accepted only while idle; requests during a run are dropped.
// Ports: clk, rst (async, active-high), start/Sub/A/B request ->
//        busy, done (1-cycle pulse), Sum/Cout/Ovf (held until the next done).
module multiword_add_sequencer
  import adder_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 Sub,
  input  logic [N*WORDS-1:0]   A,
  input  logic [N*WORDS-1:0]   B,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   Sum,
  output logic                 Cout,
  output logic                 Ovf
);

  localparam int W  = N * WORDS;
  localparam int IW = $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;   // already inverted for subtract
  logic [W-1:0]    acc_q;
  logic            carry_q;
  logic [IW-1:0]   idx;

  logic [N-1:0]    chunk_a;
  logic [N-1:0]    chunk_b;
  logic [N-1:0]    chunk_sum;
  logic            chunk_cout;
  logic [W-1:0]    final_sum;

  assign chunk_a = a_q[idx*N +: N];
  assign chunk_b = b_q[idx*N +: N];

  ripple_carry_adder #(.N(N)) u_rca (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // On the last run cycle the top chunk comes straight from the adder, so the
  // published result includes the chunk being written at that same edge.
  assign final_sum = {chunk_sum, acc_q[W-N-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= Sub ? ~B : B;
            // Subtract is A + ~B + 1: the +1 enters as the first carry-in.
            carry_q <= Sub;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q[idx*N +: N] <= chunk_sum;
          carry_q           <= chunk_cout;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            Sum   <= final_sum;
            Cout  <= chunk_cout;
            // Like-signed operands producing an opposite-signed result.
            Ovf   <= (a_q[W-1] == b_q[W-1]) && (final_sum[W-1] != a_q[W-1]);
            state <= S_IDLE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule : multiword_add_sequencer

// File: tb/tb_multiword_add_sequencer.sv
module tb_multiword_add_sequencer;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         Sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout),
    .Ovf   (Ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops the oldest expected result and compares.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending result");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum",  32'(Sum),  32'(e.sum));
        chk("cout", 32'(Cout), 32'(e.cout));
        chk("ovf",  32'(Ovf),  32'(e.ovf));
        chk("busy_with_done", 32'(busy), 32'd0);
      end
    end
  end

  // Wait (bounded) for done after the start edge; checks busy each cycle and latency.
  task automatic wait_done(input string name);
    int cycles = 0;
    chk({name, "_busy_after_start"}, 32'(busy), 32'd1);
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (done !== 1'b1 && cycles < WORDS)
        chk({name, "_busy_run"}, 32'(busy), 32'd1);
    end
    chk({name, "_latency"}, 32'(cycles), 32'(WORDS));
  endtask

  // Called just after a clock edge; the request is sampled at the next edge.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    A = a; B = b; Sub = sub; start = 1'b1;
    e.sum = es; e.cout = ec; e.ovf = eo;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(name);
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    logic [W-1:0] held;
    rst = 1'b1; start = 1'b0; Sub = 1'b0; A = '0; B = '0;
    @(posedge clk); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(Sum),  32'd0);
    chk("rst_cout", 32'(Cout), 32'd0);
    chk("rst_ovf",  32'(Ovf),  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors with hand-computed results; consecutive calls are back-to-back.
    run_op("add_carry",  16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    run_op("full_ripple",16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    // Started in the previous done cycle.
    run_op("b2b",        16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

    // Result holds while idle.
    held = Sum;
    repeat (3) @(posedge clk);
    #1;
    chk("sum_hold", 32'(Sum), 32'(held));

    // start held high and operands changed during the run.
    A = 16'h1111; B = 16'h2222; Sub = 1'b0; start = 1'b1;
    e.sum = 16'h3333; e.cout = 1'b0; e.ovf = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    A = 16'hFFFF; B = 16'hFFFF; Sub = 1'b1;
    wait_done("hold_start");
    start = 1'b0;
    @(posedge clk); #1;
    chk("no_restart_busy", 32'(busy), 32'd0);

    // Reset during the second run cycle aborts the operation.
    A = 16'h0F0F; B = 16'h0101; Sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(Sum),  32'd0);
    chk("abort_cout", 32'(Cout), 32'd0);
    chk("abort_ovf",  32'(Ovf),  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_still_idle", 32'(busy), 32'd0);

    run_op("after_reset", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_multiword_add_sequencer
